// File: rtl/add64_issue_stage.sv
// Issue/result stage for an external W-bit adder: request FIFO, operand mapping with
// carry chaining for ADC/SBB, registered result with flags on a valid/ready handshake.
module add64_issue_stage #(
    parameter int W     = 64,
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [W-1:0]     add_a,
    output logic [W-1:0]     add_b,
    output logic             add_ci,
    input  logic [W-1:0]     add_s,
    input  logic             add_co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_s,
    output logic             out_c,
    output logic             out_v,
    output logic             out_z,
    output logic             out_n,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBB = 2'b11
    } op_e;

    typedef struct packed {
        op_e              op;
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        logic [TAG_W-1:0] tag;
    } req_t;

    req_t          mem [DEPTH];
    req_t          head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          cf;
    logic          push, issue, empty, full;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready && !flush;
    assign issue    = !empty && (!out_valid || out_ready) && !flush;

    // Operands are always presented from the head; they only matter on an issue cycle.
    always_comb begin
        head   = mem[rd_ptr];
        add_a  = head.a;
        add_b  = head.op[0] ? ~head.b : head.b;
        add_ci = cf;
        case (head.op)
            OP_ADD:  add_ci = 1'b0;
            OP_SUB:  add_ci = 1'b1;
            default: add_ci = cf;
        endcase
    end

    // NOTE: storage has no reset; validity is tracked by count, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{op: op_e'(in_op), a: in_a, b: in_b, tag: in_tag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + PW'(1);
            if (issue) rd_ptr <= rd_ptr + PW'(1);
            case ({push, issue})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Result register: loads on issue, holds under backpressure, drops valid on consume-only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_s     <= '0;
            out_c     <= 1'b0;
            out_v     <= 1'b0;
            out_z     <= 1'b0;
            out_n     <= 1'b0;
            out_tag   <= '0;
            cf        <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_s     <= '0;
            out_c     <= 1'b0;
            out_v     <= 1'b0;
            out_z     <= 1'b0;
            out_n     <= 1'b0;
            out_tag   <= '0;
            cf        <= 1'b0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_s     <= add_s;
            out_c     <= add_co;
            out_v     <= (add_a[W-1] == add_b[W-1]) && (add_s[W-1] != add_a[W-1]);
            out_z     <= (add_s == '0);
            out_n     <= add_s[W-1];
            out_tag   <= head.tag;
            cf        <= add_co;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
